// File: rtl/adder_serial_fa_if.sv
// Start/busy/done handshake and operand/result bundle for the digit-serial adder.
// The master drives the request side; the slave (the adder) returns status and results.
interface adder_serial_fa_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, A, B, cin,
        input  busy, done, Sum, cout, ovf
    );

    modport slave (
        input  start, sub, A, B, cin,
        output busy, done, Sum, cout, ovf
    );
endinterface

// File: rtl/adder_serial_fa.sv
// Digit-serial add/subtract: DIGIT bits per clock through a small full-adder chain,
// LSB digit first, with the carry held in a flop between digits.
module adder_serial_fa #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic              clk,
    input  logic              rst,
    adder_serial_fa_if.slave  bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (WIDTH % DIGIT != 0) begin : g_bad_digit
            $error("adder_serial_fa: WIDTH must be a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             ovf_r;

    logic [DIGIT-1:0] dsum;
    logic [DIGIT:0]   c;
    logic [WIDTH-1:0] res_next;
    logic             last;

    assign last = (count == CW'(N - 1));

    // One digit of ripple addition; result digits enter at the top and shift down,
    // so after N digits the LSB digit has reached bit 0.
    always_comb begin
        c        = '0;
        dsum     = '0;
        c[0]     = carry;
        for (int i = 0; i < DIGIT; i++) begin
            dsum[i]  = a_sh[i] ^ b_sh[i] ^ c[i];
            c[i+1]   = (a_sh[i] & b_sh[i]) | (c[i] & (a_sh[i] ^ b_sh[i]));
        end
        res_next = res >> DIGIT;
        res_next[WIDTH-1 -: DIGIT] = dsum;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            count  <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            res    <= '0;
            carry  <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            sum_r  <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sh   <= bus.A;
                        b_sh   <= bus.sub ? ~bus.B : bus.B;
                        carry  <= bus.sub ? ~bus.cin : bus.cin;
                        count  <= '0;
                        busy_r <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> DIGIT;
                    b_sh  <= b_sh >> DIGIT;
                    res   <= res_next;
                    carry <= c[DIGIT];
                    count <= count + 1'b1;
                    // Carry into the MSB is the second-to-last carry of the final digit.
                    if (last) begin
                        sum_r  <= res_next;
                        cout_r <= c[DIGIT];
                        ovf_r  <= c[DIGIT] ^ c[DIGIT-1];
                        done_r <= 1'b1;
                        busy_r <= 1'b0;
                        count  <= '0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.Sum  = sum_r;
    assign bus.cout = cout_r;
    assign bus.ovf  = ovf_r;
endmodule

// File: tb/tb_adder_serial_fa.sv
// Self-checking bench for adder_serial_fa: an 8-bit/2-bit-digit unit plus two 4-bit
// variants (1-bit and 4-bit digits) swept exhaustively against an arithmetic model.
module tb_adder_serial_fa;
    logic clk;
    logic rst;
    int   total;
    int   bad;
    logic [9:0] exp_prev;

    adder_serial_fa_if #(.WIDTH(8)) m8 ();
    adder_serial_fa_if #(.WIDTH(4)) m41 ();
    adder_serial_fa_if #(.WIDTH(4)) m44 ();

    adder_serial_fa #(.WIDTH(8), .DIGIT(2)) dut8  (.clk(clk), .rst(rst), .bus(m8));
    adder_serial_fa #(.WIDTH(4), .DIGIT(1)) dut41 (.clk(clk), .rst(rst), .bus(m41));
    adder_serial_fa #(.WIDTH(4), .DIGIT(4)) dut44 (.clk(clk), .rst(rst), .bus(m44));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Returns {cout, ovf, Sum zero-extended to 8 bits} from plain integer arithmetic.
    function automatic logic [9:0] model(input int w, input logic s, input int a, input int b,
                                         input logic c);
        int mask, half, sa, sb, r_u, r_s;
        logic co, ov;
        mask = (1 << w) - 1;
        half = 1 << (w - 1);
        sa = (a >= half) ? a - (1 << w) : a;
        sb = (b >= half) ? b - (1 << w) : b;
        if (!s) begin
            r_u = a + b + int'(c);
            co  = (r_u > mask);
            r_s = sa + sb + int'(c);
        end else begin
            r_u = a - b - int'(c);
            co  = (a >= b + int'(c));
            r_s = sa - sb - int'(c);
        end
        ov = (r_s < -half) || (r_s > half - 1);
        return {co, ov, 8'(r_u & mask)};
    endfunction

    // Presents one request, waits for the accepting edge, then scrambles the operands.
    task automatic applyStimulus(input logic s, input logic [7:0] a, input logic [7:0] b,
                                 input logic c);
        m8.start = 1'b1;
        m8.sub   = s;
        m8.A     = a;
        m8.B     = b;
        m8.cin   = c;
        @(posedge clk); #1;
        m8.start = 1'b0;
        m8.A     = 8'($urandom);
        m8.B     = 8'($urandom);
        m8.cin   = 1'($urandom);
        m8.sub   = 1'($urandom);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        m8.start = 1'b1;
        m8.A = 8'hFF;
        m8.B = 8'h01;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({m8.busy, m8.done, m8.cout, m8.ovf, m8.Sum} !== 12'h000) begin
            bad++;
            $display("[TB] FAIL reset_state got busy=%0b done=%0b cout=%0b ovf=%0b Sum=%h required all 0",
                     m8.busy, m8.done, m8.cout, m8.ovf, m8.Sum);
        end
        m8.start = 1'b0;
        rst = 1'b0;
        exp_prev = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_arith(input int nrand);
        logic [17:0] vec [5];
        logic [17:0] v;
        logic [9:0]  exp;
        logic        hold_ok;
        int          cyc;
        vec[0] = {1'b0, 8'h0F, 8'h01, 1'b0};
        vec[1] = {1'b0, 8'hFF, 8'h01, 1'b0};
        vec[2] = {1'b0, 8'h7F, 8'h01, 1'b0};
        vec[3] = {1'b1, 8'h05, 8'h07, 1'b0};
        vec[4] = {1'b1, 8'h80, 8'h01, 1'b0};
        for (int i = 0; i < 5 + nrand; i++) begin
            v = (i < 5) ? vec[i] : 18'($urandom);
            exp = model(8, v[17], int'(v[16:9]), int'(v[8:1]), v[0]);
            applyStimulus(v[17], v[16:9], v[8:1], v[0]);
            cyc = 0;
            hold_ok = 1'b1;
            while (m8.done !== 1'b1 && cyc < 12) begin
                if (m8.busy !== 1'b1 || {m8.cout, m8.ovf, m8.Sum} !== exp_prev) hold_ok = 1'b0;
                @(posedge clk); #1;
                cyc++;
            end
            total++;
            if (cyc != 4 || !hold_ok) begin
                bad++;
                $display("[TB] FAIL op%0d_timing got cycles=%0d busy_and_hold=%0b required cycles=4 busy_and_hold=1",
                         i, cyc, hold_ok);
            end
            total++;
            if ({m8.cout, m8.ovf, m8.Sum} !== exp) begin
                bad++;
                $display("[TB] FAIL op%0d_result sub=%0b A=%h B=%h cin=%0b got cout=%0b ovf=%0b Sum=%h required cout=%0b ovf=%0b Sum=%h",
                         i, v[17], v[16:9], v[8:1], v[0], m8.cout, m8.ovf, m8.Sum, exp[9], exp[8], exp[7:0]);
            end
            exp_prev = exp;
            @(posedge clk); #1;
            total++;
            if (m8.done !== 1'b0 || m8.busy !== 1'b0) begin
                bad++;
                $display("[TB] FAIL op%0d_idle got done=%0b busy=%0b required done=0 busy=0", i, m8.done, m8.busy);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [9:0] exp;
        logic [7:0] a, b;
        int cyc;
        exp = model(8, 1'b0, 32'h10, 32'h20, 1'b0);
        applyStimulus(1'b0, 8'h10, 8'h20, 1'b0);
        @(posedge clk); #1;
        m8.start = 1'b1;
        m8.A = 8'hFF;
        m8.B = 8'hFF;
        @(posedge clk); #1;
        m8.start = 1'b0;
        @(posedge clk); #1;
        total++;
        if (m8.done !== 1'b0 || m8.busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL ignore_start_early got done=%0b busy=%0b required done=0 busy=1", m8.done, m8.busy);
        end
        @(posedge clk); #1;
        total++;
        if (m8.done !== 1'b1 || {m8.cout, m8.ovf, m8.Sum} !== exp) begin
            bad++;
            $display("[TB] FAIL ignore_start_result got done=%0b Sum=%h required done=1 Sum=%h",
                     m8.done, m8.Sum, exp[7:0]);
        end
        exp_prev = exp;
        a = 8'($urandom);
        b = 8'($urandom);
        exp = model(8, 1'b1, int'(a), int'(b), 1'b1);
        applyStimulus(1'b1, a, b, 1'b1);
        total++;
        if (m8.done !== 1'b0 || m8.busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL b2b_accept got done=%0b busy=%0b required done=0 busy=1", m8.done, m8.busy);
        end
        cyc = 0;
        while (m8.done !== 1'b1 && cyc < 12) begin
            @(posedge clk); #1;
            cyc++;
        end
        total++;
        if (cyc != 4 || {m8.cout, m8.ovf, m8.Sum} !== exp) begin
            bad++;
            $display("[TB] FAIL b2b_result got cycles=%0d result=%h required cycles=4 result=%h",
                     cyc, {m8.cout, m8.ovf, m8.Sum}, exp);
        end
        exp_prev = exp;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midrun;
        logic [9:0] exp;
        logic [7:0] a, b;
        int cyc, pulses;
        applyStimulus(1'b0, 8'h50, 8'h05, 1'b0);
        cyc = 0;
        while (m8.done !== 1'b1 && cyc < 12) begin
            @(posedge clk); #1;
            cyc++;
        end
        total++;
        if (m8.Sum !== 8'h55) begin
            bad++;
            $display("[TB] FAIL prior_result got Sum=%h required Sum=55", m8.Sum);
        end
        @(posedge clk); #1;
        applyStimulus(1'b1, 8'($urandom), 8'($urandom), 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++;
        if ({m8.busy, m8.done, m8.cout, m8.ovf, m8.Sum} !== 12'h000) begin
            bad++;
            $display("[TB] FAIL midrun_reset got busy=%0b done=%0b cout=%0b ovf=%0b Sum=%h required all 0",
                     m8.busy, m8.done, m8.cout, m8.ovf, m8.Sum);
        end
        pulses = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (m8.done === 1'b1 || m8.busy === 1'b1) pulses++;
        end
        total++;
        if (pulses != 0) begin
            bad++;
            $display("[TB] FAIL aborted_no_done got active_cycles=%0d required 0", pulses);
        end
        exp_prev = '0;
        a = 8'($urandom);
        b = 8'($urandom);
        exp = model(8, 1'b0, int'(a), int'(b), 1'b1);
        applyStimulus(1'b0, a, b, 1'b1);
        cyc = 0;
        while (m8.done !== 1'b1 && cyc < 12) begin
            @(posedge clk); #1;
            cyc++;
        end
        total++;
        if (cyc != 4 || {m8.cout, m8.ovf, m8.Sum} !== exp) begin
            bad++;
            $display("[TB] FAIL after_reset_op got cycles=%0d result=%h required cycles=4 result=%h",
                     cyc, {m8.cout, m8.ovf, m8.Sum}, exp);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_sweep_small;
        logic [9:0] exp;
        logic [5:0] r1, r4, e6;
        int k1, k4;
        for (int s = 0; s < 2; s++) begin
            for (int c = 0; c < 2; c++) begin
                for (int a = 0; a < 16; a++) begin
                    for (int b = 0; b < 16; b++) begin
                        m41.start = 1'b1;  m44.start = 1'b1;
                        m41.sub = 1'(s);   m44.sub = 1'(s);
                        m41.cin = 1'(c);   m44.cin = 1'(c);
                        m41.A = 4'(a);     m44.A = 4'(a);
                        m41.B = 4'(b);     m44.B = 4'(b);
                        @(posedge clk); #1;
                        m41.start = 1'b0;  m44.start = 1'b0;
                        r1 = 'x; r4 = 'x; k1 = 0; k4 = 0;
                        for (int k = 1; k <= 6; k++) begin
                            @(posedge clk); #1;
                            if (m41.done === 1'b1 && k1 == 0) begin
                                r1 = {m41.cout, m41.ovf, m41.Sum};
                                k1 = k;
                            end
                            if (m44.done === 1'b1 && k4 == 0) begin
                                r4 = {m44.cout, m44.ovf, m44.Sum};
                                k4 = k;
                            end
                        end
                        exp = model(4, 1'(s), a, b, 1'(c));
                        e6 = {exp[9:8], exp[3:0]};
                        total++;
                        if (r1 !== e6 || k1 != 4) begin
                            bad++;
                            $display("[TB] FAIL sweep_d1 sub=%0d A=%h B=%h cin=%0d got {cout,ovf,Sum}=%h lat=%0d required %h lat=4",
                                     s, a, b, c, r1, k1, e6);
                        end
                        total++;
                        if (r4 !== e6 || k4 != 1) begin
                            bad++;
                            $display("[TB] FAIL sweep_d4 sub=%0d A=%h B=%h cin=%0d got {cout,ovf,Sum}=%h lat=%0d required %h lat=1",
                                     s, a, b, c, r4, k4, e6);
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        exp_prev = '0;
        rst = 1'b1;
        m8.start = 1'b0;  m8.sub = 1'b0;  m8.A = '0;  m8.B = '0;  m8.cin = 1'b0;
        m41.start = 1'b0; m41.sub = 1'b0; m41.A = '0; m41.B = '0; m41.cin = 1'b0;
        m44.start = 1'b0; m44.sub = 1'b0; m44.A = '0; m44.B = '0; m44.cin = 1'b0;
        test_reset();
        test_arith(40);
        test_back_to_back();
        test_reset_midrun();
        test_sweep_small();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
